seq_divider: RTL and testbench

- Iterative restoring divider; the inverse of the team's 5x5 array multiplier.
- Takes a 2W-bit dividend (a product-width operand) and a W-bit divisor.
- Produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock.
- Sits behind a valid/ready handshake on both input and output, so it can be chained after the multiplier for round-trip checking.

---
 rtl/seq_divider_pkg.sv | 6 +
 rtl/div_step.sv | 16 +
 rtl/seq_divider.sv | 72 +++++++
 tb/tb_seq_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and constants for the sequential divider
package seq_divider_pkg;
  localparam int W_DEF = 5;
  localparam logic [2*W_DEF-1:0] DIVZ_Q = {(2*W_DEF){1'b1}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, shifting in one dividend bit
module div_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] rem,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] shifted, trial;
  assign shifted  = {rem, next_bit};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[W];
  assign rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 2W/W -> 2W quotient and W remainder, valid/ready on both sides
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);
  localparam int CNT_W = $clog2(2*W+1);
  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0] q;
  logic [W-1:0] rem, rem_step, dvs;
  logic q_bit, dbz, zero_div;
  assign zero_div    = divisor == '0;
  assign in_ready    = state == IDLE;
  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;
  div_step #(.W(W)) u_step (
    .rem(rem),
    .next_bit(q[2*W-1]),
    .divisor(dvs),
    .rem_next(rem_step),
    .q_bit(q_bit)
  );
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = zero_div ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // out_valid trails DONE entry by one edge so it is a clean register, never a decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      rem       <= '0;
      dvs       <= '0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= state == DONE && !(out_valid && out_ready);
      if (state == IDLE && in_valid) begin
        dvs <= divisor;
        dbz <= zero_div;
        q   <= zero_div ? DIVZ_Q[2*W-1:0] : dividend;
        rem <= zero_div ? dividend[W-1:0] : '0;
        cnt <= zero_div ? '0 : CNT_W'(2*W);
      end else if (state == RUN) begin
        rem <= rem_step;
        q   <= {q[2*W-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
  localparam int W = 5;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_by_zero;
  logic [2*W-1:0] dividend = '0, quotient;
  logic [W-1:0] divisor = '0, remainder;
  int errors = 0, checks = 0;

  seq_divider #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int a, input int b);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    dividend = (2*W)'(a);
    divisor  = W'(b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // lat: edges still expected between now and out_valid rising
  task automatic wait_result(input int a, input int b, input int lat);
    int n = 0;
    int eq, er;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("latency", n, lat);
    eq = (b == 0) ? (1 << (2*W)) - 1 : a / b;
    er = (b == 0) ? a % (1 << W) : a % b;
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, b == 0);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ack_out_valid", out_valid, 0);
    check("ack_in_ready", in_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_div_by_zero"}, div_by_zero, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check_reset_values("reset");
    @(negedge clk) rst = 1'b0;
    step();
    start(1023, 31); wait_result(1023, 31, 11); ack();
    start(1000, 7);  wait_result(1000, 7, 11);  ack();
    start(961, 31);  wait_result(961, 31, 11);  ack();
    start(5, 9);     wait_result(5, 9, 11);     ack();
    start(0, 13);    wait_result(0, 13, 11);    ack();
    start(100, 0);   wait_result(100, 0, 1);    ack();
    // backpressure: result must hold while the consumer stalls
    start(1000, 7);
    wait_result(1000, 7, 11);
    for (int i = 0; i < 20; i++) begin
      step();
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_quotient", quotient, 142);
      check("stall_remainder", remainder, 6);
    end
    ack();
    // operands offered mid-run must not disturb the active division
    start(1000, 7);
    repeat (3) step();
    dividend = 10'd7;
    divisor  = 5'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_result(1000, 7, 7);
    ack();
    // reset in the middle of a run
    start(1000, 7);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check_reset_values("rst_run");
    @(negedge clk) rst = 1'b0;
    repeat (15) step();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    start(1023, 31); wait_result(1023, 31, 11); ack();
    // reset while a divide-by-zero result is waiting
    start(100, 0);
    wait_result(100, 0, 1);
    rst = 1'b1;
    #1;
    check_reset_values("rst_done");
    @(negedge clk) rst = 1'b0;
    step();
    // multiplier round trip over all nonzero 5-bit operand pairs
    for (int a = 1; a < 32; a++)
      for (int b = 1; b < 32; b++) begin
        start(a * b, b);
        wait_result(a * b, b, 11);
        ack();
      end
    for (int i = 0; i < 300; i++) begin
      int a, b;
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 31));
      start(a, b);
      wait_result(a, b, b == 0 ? 1 : 11);
      repeat ($urandom_range(0, 3)) step();
      check("rand_hold_quotient", quotient, b == 0 ? 1023 : a / b);
      ack();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
